// File: rtl/fpmul_stream_ctrl.sv
// Valid/ready stream wrapper around a fixed-latency, non-stallable FP multiplier.
// Credits cover both in-flight and buffered results, so the result FIFO can never overflow.
module fpmul_stream_ctrl #(
  parameter int N     = 32,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] mul_a,
  output logic [N-1:0] mul_b,
  input  logic [N-1:0] mul_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  mul_a_q, mul_a_d;
  logic [N-1:0]  mul_b_q, mul_b_d;
  logic [LAT:0]  vld_sr_q, vld_sr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          in_ready_q, in_ready_d;
  logic [N-1:0]  fifo_mem [DEPTH];

  logic issue;
  logic pop;
  logic fifo_wr;
  logic fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);
  assign issue         = in_valid & in_ready_q;
  assign pop           = fifo_nonempty & out_ready;
  // The multiplier output is only meaningful when the tracked op reaches the last stage.
  assign fifo_wr       = vld_sr_q[LAT];

  always_comb begin
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    vld_sr_d   = {vld_sr_q[LAT-1:0], issue};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credits_d  = credits_q;
    in_ready_d = in_ready_q;

    if (issue) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
    end

    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    count_d    = count_q + CW'(fifo_wr) - CW'(pop);
    credits_d  = credits_q + CW'(issue) - CW'(pop);
    in_ready_d = (credits_d < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      vld_sr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credits_q  <= '0;
      in_ready_q <= 1'b0;
    end else begin
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      vld_sr_q   <= vld_sr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage array carries no reset; stale contents are masked by count_q.
  always_ff @(posedge clk) begin
    if (rst_n && fifo_wr) begin
      fifo_mem[wr_ptr_q] <= mul_z;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = fifo_nonempty;
  assign out_data  = fifo_nonempty ? fifo_mem[rd_ptr_q] : '0;
  assign busy      = (credits_q != '0);

endmodule

// File: tb/tb_fpmul_stream_ctrl.sv
// Bench for fpmul_stream_ctrl: models the FPmul pipeline and checks the stream against a
// queue-based reference that tracks each accepted op and the edge its result becomes visible.
module tb_fpmul_stream_ctrl;
  localparam int N     = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic [N-1:0] mul_z;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic         busy;

  fpmul_stream_ctrl #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] x);
    real m;
    real p;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    p = 1.0;
    if (e >= 0) repeat (e) p = p * 2.0;
    else repeat (-e) p = p / 2.0;
    return x[31] ? -(m * p) : (m * p);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [7:0]  e8;
    if (r == 0.0) return 32'd0;
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 1023 + 127;
    e8 = e[7:0];
    return {d[63], e8, d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] i2f(input int k);
    return r2f(real'(k));
  endfunction

  // Behavioural FPmul: non-stallable, no reset, LAT edges from operands to product.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mul_z = pipe[LAT-1];

  typedef struct {
    logic [31:0] z;
    int          t;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   issued_cnt = 0;
  bit   last_issue;
  bit   last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs just after a falling edge, score the handshake, check after the edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = r;
    #1;
    last_issue = in_valid && in_ready;
    last_pop   = out_valid && out_ready;
    if (last_pop) begin
      if (q.size() == 0) chk("pop_without_result", 32'd1, 32'd0);
      else chk("out_data", out_data, q[0].z);
    end
    @(posedge clk);
    edge_n++;
    if (last_pop && q.size() > 0) void'(q.pop_front());
    if (last_issue) begin
      q.push_back('{z: fmul(a, b), t: edge_n + LAT + 1});
      issued_cnt++;
    end
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0 && q[0].t <= edge_n));
    chk("credits_bound", 32'(dut.credits_q <= DEPTH), 32'd1);
    if (dut.vld_sr_q[LAT]) chk("fifo_write_not_full", 32'(dut.count_q < DEPTH), 32'd1);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b1);
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int first_edge;
    int issue_edge;
    int start;
    int budget;
    logic [31:0] ra;
    logic [31:0] rb;

    @(negedge clk);
    do_reset();
    cyc(1'b0, 32'd0, 32'd0, 1'b1);

    // Single op: 2.0 * 2.0 visible LAT+1 edges after the accepting edge, for one cycle.
    cyc(1'b1, 32'h4000_0000, 32'h4000_0000, 1'b1);
    chk("single_issue", 32'(last_issue), 32'd1);
    issue_edge = edge_n;
    first_edge = -1;
    for (int i = 0; i < 10 && first_edge < 0; i++) begin
      if (out_valid) begin
        first_edge = edge_n;
        chk("single_data", out_data, 32'h4080_0000);
      end
      cyc(1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("single_latency", 32'(first_edge - issue_edge), 32'(LAT + 1));
    chk("single_one_cycle", 32'(out_valid), 32'd0);
    chk("single_busy_clear", 32'(busy), 32'd0);

    // Streaming: 100 back-to-back k*k with the consumer always ready.
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      cyc(1'b1, i2f(k), i2f(k), 1'b1);
      cnt += int'(last_issue);
    end
    chk("stream_accepted", 32'(cnt), 32'd100);
    drain(20);

    // Backpressure: only DEPTH accepted, then drain in order.
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, i2f(k + 3), i2f(-(k + 1)), 1'b0);
      cnt += int'(last_issue);
    end
    chk("bp_accepted", 32'(cnt), 32'(DEPTH));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_operands_held", mul_a, i2f(DEPTH + 2));
    cyc(1'b0, 32'd0, 32'd0, 1'b1);
    chk("bp_first_pop", 32'(last_pop), 32'd1);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    drain(20);

    // Issue and pop together with DEPTH-1 credits outstanding.
    for (int k = 0; k < DEPTH - 1; k++) cyc(1'b1, i2f(k + 11), i2f(7), 1'b0);
    repeat (LAT + 2) cyc(1'b0, 32'd0, 32'd0, 1'b0);
    chk("pre_credits", 32'(dut.credits_q), 32'(DEPTH - 1));
    cyc(1'b1, i2f(99), i2f(5), 1'b1);
    chk("both_issue", 32'(last_issue), 32'd1);
    chk("both_pop", 32'(last_pop), 32'd1);
    chk("both_credits", 32'(dut.credits_q), 32'(DEPTH - 1));
    drain(30);

    // Reset with 3 ops in flight and 2 buffered; nothing stale may appear afterwards.
    for (int k = 0; k < 5; k++) cyc(1'b1, i2f(k + 21), i2f(3), 1'b0);
    repeat (2) cyc(1'b0, 32'd0, 32'd0, 1'b0);
    chk("pre_reset_buffered", 32'(out_valid), 32'd1);
    do_reset();
    repeat (10) cyc(1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b1, i2f(3), i2f(3), 1'b1);
    drain(20);
    chk("post_reset_count", 32'(q.size()), 32'd0);

    // Random traffic against the reference queue.
    start  = issued_cnt;
    budget = 0;
    while (issued_cnt - start < 10000 && budget < 40000) begin
      ra = i2f(int'($urandom_range(1, 2000)) * (($urandom_range(0, 1) == 0) ? 1 : -1));
      rb = i2f(int'($urandom_range(1, 2000)));
      cyc(1'($urandom_range(0, 99) < 70), ra, rb, 1'($urandom_range(0, 99) < 70));
      budget++;
    end
    chk("random_ops_done", 32'(issued_cnt - start >= 10000), 32'd1);
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
